// File: rtl/hash_port_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the hash-port arbiter.
// Latency: none, declarations only.
// Backpressure: not applicable.
package hash_port_arbiter_pkg;

    localparam int HPA_NUM_PROCESSOR    = 3;
    localparam int HPA_BIT_ON_TAILS     = 7;
    localparam int HPA_DATA_INDEX_WIDTH = 32;
    localparam int HPA_MAX_HOLD         = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so single-entry ranges still get a bit.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

    // Round-robin distance of candidate from the slot after base: base+1 -> 0, base -> n-1.
    function automatic int rr_dist(input int base, input int cand, input int n);
        int d;
        d = cand - base - 1;
        if (d < 0) begin
            d = d + n;
        end
        return d;
    endfunction

endpackage

// File: rtl/hash_port_arbiter_if.sv
// Processor-array and hash-memory signals seen by the port arbiter.
// Latency: none, wiring only.
// Backpressure: gnt is the only flow control towards the processors.
interface hash_port_arbiter_if
    import hash_port_arbiter_pkg::*;
#(
    parameter int NUM_PROCESSOR = HPA_NUM_PROCESSOR,
    parameter int ADDR_WIDTH    = HPA_BIT_ON_TAILS,
    parameter int DATA_WIDTH    = HPA_DATA_INDEX_WIDTH
);
    logic [NUM_PROCESSOR-1:0]            req;
    logic [NUM_PROCESSOR-1:0]            lock;
    logic [NUM_PROCESSOR-1:0]            we;
    logic [NUM_PROCESSOR*ADDR_WIDTH-1:0] addr;
    logic [NUM_PROCESSOR*DATA_WIDTH-1:0] wdata;
    logic [NUM_PROCESSOR-1:0]            gnt;
    logic [NUM_PROCESSOR-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]               rdata;
    logic                                mem_en;
    logic                                mem_we;
    logic [ADDR_WIDTH-1:0]               mem_addr;
    logic [DATA_WIDTH-1:0]               mem_wdata;
    logic [DATA_WIDTH-1:0]               mem_rdata;
    logic                                busy;

    // Processor array plus memory: drives requests and read data.
    modport master (
        output req, lock, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Arbiter: owns grants and the memory strobe.
    modport slave (
        input  req, lock, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/hash_port_arbiter_rr_pick.sv
// Round-robin pick: first requester after base, wrapping, as one-hot plus index.
// Latency: purely combinational.
// Backpressure: none; valid low when no request is present.
module hash_port_arbiter_rr_pick
    import hash_port_arbiter_pkg::*;
#(
    parameter int NUM_PROCESSOR = HPA_NUM_PROCESSOR,
    parameter int IDX_WIDTH     = log2(HPA_NUM_PROCESSOR)
) (
    input  logic [NUM_PROCESSOR-1:0] req,
    input  logic [IDX_WIDTH-1:0]     base,
    output logic [NUM_PROCESSOR-1:0] pick_oh,
    output logic [IDX_WIDTH-1:0]     pick_idx,
    output logic                     pick_vld
);
    int best_d;

    // Keep the requester closest (in rotation order) to the slot after base.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        best_d   = NUM_PROCESSOR;
        for (int j = 0; j < NUM_PROCESSOR; j++) begin
            if (req[j] && (rr_dist(int'(base), j, NUM_PROCESSOR) < best_d)) begin
                best_d      = rr_dist(int'(base), j, NUM_PROCESSOR);
                pick_vld    = 1'b1;
                pick_idx    = IDX_WIDTH'(j);
                pick_oh     = '0;
                pick_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_port_arbiter.sv
// Round-robin owner of the shared hash-array port, with locked RMW runs and capped unlocked bursts.
// Latency: gnt one cycle after req; memory strobe combinational in the granted beat; rvalid one cycle after a read beat.
// Backpressure: requesters hold req until their beat is done; gnt is the only throttle, nothing is buffered.
module hash_port_arbiter
    import hash_port_arbiter_pkg::*;
#(
    parameter int NUM_PROCESSOR = HPA_NUM_PROCESSOR,
    parameter int BIT_ON_TAILS  = HPA_BIT_ON_TAILS,
    parameter int DATA_WIDTH    = HPA_DATA_INDEX_WIDTH,
    parameter int MAX_HOLD      = HPA_MAX_HOLD
) (
    input logic                clk,
    input logic                rst_n,
    hash_port_arbiter_if.slave bus
);
    localparam int ADDR_WIDTH = BIT_ON_TAILS;
    localparam int IW         = log2(NUM_PROCESSOR);
    localparam int HW         = log2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_e               state;
    logic [NUM_PROCESSOR-1:0] gnt_q;
    logic [NUM_PROCESSOR-1:0] rvalid_q;
    logic [IW-1:0]            owner_q;
    logic [IW-1:0]            last_owner_q;
    logic [HW-1:0]            hold_cnt;

    logic                     own_req;
    logic                     own_lock;
    logic                     own_we;
    logic [ADDR_WIDTH-1:0]    own_addr;
    logic [DATA_WIDTH-1:0]    own_wdata;
    logic                     beat;
    logic                     others_pend;
    logic                     forced;
    logic                     release_now;

    logic [NUM_PROCESSOR-1:0] pick_req;
    logic [IW-1:0]            pick_base;
    logic [NUM_PROCESSOR-1:0] pick_oh;
    logic [IW-1:0]            pick_idx;
    logic                     pick_vld;

    // Select the current owner's request lane.
    always_comb begin
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_PROCESSOR; i++) begin
            if (owner_q == IW'(i)) begin
                own_req   = bus.req[i];
                own_lock  = bus.lock[i];
                own_we    = bus.we[i];
                own_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_wdata = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // gnt_q is one-hot on the owner while owning, so masking it leaves the waiting requesters.
    assign beat        = (state == ST_OWN) && own_req;
    assign others_pend = |(bus.req & ~gnt_q);
    assign forced      = beat && !own_lock && others_pend && (hold_cnt == HOLD_LAST);
    assign release_now = (state == ST_OWN) && (!own_req || forced);

    // On release the scan starts after the outgoing owner and skips it, so it cannot win straight back.
    assign pick_req  = (state == ST_OWN) ? (bus.req & ~gnt_q) : bus.req;
    assign pick_base = (state == ST_OWN) ? owner_q : last_owner_q;

    hash_port_arbiter_rr_pick #(
        .NUM_PROCESSOR (NUM_PROCESSOR),
        .IDX_WIDTH     (IW)
    ) u_rr_pick (
        .req      (pick_req),
        .base     (pick_base),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    // Ownership FSM: grant, hand over directly owner-to-owner, and track the unlocked-burst count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NUM_PROCESSOR - 1);
            hold_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    if (pick_vld) begin
                        state   <= ST_OWN;
                        gnt_q   <= pick_oh;
                        owner_q <= pick_idx;
                    end
                end
                ST_OWN: begin
                    if (release_now) begin
                        last_owner_q <= owner_q;
                        hold_cnt     <= '0;
                        if (pick_vld) begin
                            gnt_q   <= pick_oh;
                            owner_q <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                            gnt_q <= '0;
                        end
                    end else if (!others_pend) begin
                        hold_cnt <= '0;
                    end else if (!own_lock && (hold_cnt != HOLD_LAST)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Read-return tag: captured with the read beat so a grant change next cycle cannot misroute it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= (beat && !own_we) ? gnt_q : '0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = |gnt_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = beat;
    assign bus.mem_we    = beat && own_we;
    assign bus.mem_addr  = beat ? own_addr : '0;
    assign bus.mem_wdata = beat ? own_wdata : '0;

endmodule
